// File: rtl/led_seq_pkg.sv
// Shared types and helpers for the LED sequencer.
package led_seq_pkg;
    typedef enum logic [1:0] {S_PASS = 2'b00, S_ROT = 2'b01, S_BNC = 2'b10, S_CNT = 2'b11} mode_e;
    typedef enum logic {DIR_L = 1'b0, DIR_R = 1'b1} dir_e;

    localparam logic [7:0] INIT_ROT = 8'h01;
    localparam logic [7:0] INIT_BNC = 8'h01;
    localparam logic [7:0] INIT_CNT = 8'h00;

    function automatic logic is_onehot(input logic [7:0] v);
        return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
    endfunction

    function automatic logic [7:0] init_val(input mode_e m, input logic [7:0] swt_s);
        case (m)
            S_PASS:  return swt_s;
            S_ROT:   return INIT_ROT;
            S_BNC:   return INIT_BNC;
            default: return INIT_CNT;
        endcase
    endfunction
endpackage

// File: rtl/led_seq_ctrl_debounce.sv
// Push-button debouncer: 2-flop synchroniser, stability down-counter,
// debounced level and a one-clock rising-edge pulse.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);
    localparam int W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = W'(DB_CYCLES - 1);

    logic btn_m;
    logic btn_s;
    logic [W-1:0] cnt;

    // The level only follows btn_s after it has differed for DB_CYCLES consecutive clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            rise  <= 1'b0;
            if (btn_s == level) begin
                cnt <= RELOAD;
            end else if (cnt == '0) begin
                level <= btn_s;
                rise  <= btn_s;
                cnt   <= RELOAD;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer top: switch synchroniser, step prescaler and mode FSM.
// Optional LED_SEQ_PWM_EN adds duty-cycle gating of the LED output flop.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV  = 50_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] swt,
    input  logic       btn_step,
    output logic [7:0] led
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [7:0]    swt_m;
    logic [7:0]    swt_s;
    mode_e         state, state_nxt, mode_req;
    dir_e          dir, dir_nxt;
    logic [7:0]    led_q, led_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          pause, tick, step;
    logic          btn_level, btn_rise;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_step),
        .level (btn_level),
        .rise  (btn_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            swt_m <= 8'h00;
            swt_s <= 8'h00;
        end else begin
            swt_m <= swt;
            swt_s <= swt_m;
        end
    end

    assign mode_req = mode_e'(swt_s[7:6]);
    assign pause    = swt_s[5];
    assign tick     = (presc == PRE_LAST);
    assign step     = pause ? (btn_rise & btn_level) : tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_PASS;
            dir   <= DIR_L;
            led_q <= 8'h00;
            presc <= '0;
        end else begin
            state <= state_nxt;
            dir   <= dir_nxt;
            led_q <= led_nxt;
            presc <= presc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        led_nxt   = led_q;
        presc_nxt = presc;
        if (!pause) begin
            presc_nxt = tick ? '0 : presc + 1'b1;
        end
        // A mode change wins over any step arriving in the same clock.
        if (mode_req != state) begin
            state_nxt = mode_req;
            presc_nxt = '0;
            dir_nxt   = DIR_L;
            led_nxt   = init_val(mode_req, swt_s);
        end else begin
            case (state)
                S_PASS: led_nxt = swt_s;
                S_ROT: begin
                    if (step) begin
                        led_nxt = is_onehot(led_q) ? {led_q[6:0], led_q[7]} : INIT_ROT;
                    end
                end
                S_BNC: begin
                    if (step) begin
                        if (!is_onehot(led_q)) begin
                            led_nxt = INIT_BNC;
                            dir_nxt = DIR_L;
                        end else if (dir == DIR_L) begin
                            if (led_q[7]) begin
                                dir_nxt = DIR_R;
                                led_nxt = 8'h40;
                            end else begin
                                led_nxt = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                dir_nxt = DIR_L;
                                led_nxt = 8'h02;
                            end else begin
                                led_nxt = led_q >> 1;
                            end
                        end
                    end
                end
                S_CNT: begin
                    if (step) begin
                        led_nxt = led_q + 8'd1;
                    end
                end
                default: led_nxt = led_q;
            endcase
        end
    end

`ifdef LED_SEQ_PWM_EN
    logic [1:0] pwm_cnt, pwm_nxt;
    logic [7:0] led_drv;

    // Gate with the counter value the flop will hold, so the LED flop adds no latency.
    always_comb begin
        pwm_nxt = pwm_cnt + 2'd1;
        led_drv = led_nxt & {8{pwm_nxt <= swt_s[4:3]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt <= 2'd0;
            led     <= 8'h00;
        end else begin
            pwm_cnt <= pwm_nxt;
            led     <= led_drv;
        end
    end
`else
    always_comb begin
        led = led_q;
    end
`endif
endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=4, DB_CYCLES=3.
module tb_led_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] swt;
    logic       btn_step;
    logic [7:0] led;

    int vectors = 0;
    int miscompares = 0;

    led_seq_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .swt      (swt),
        .btn_step (btn_step),
        .led      (led)
    );

    always #5 clk = ~clk;

    logic [7:0] rot_tbl [8]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    logic [7:0] bnc_tbl [15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                                 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    // Waits (bounded) until led changes; returns clocks elapsed, 64 on timeout.
    task automatic wait_change(output int n);
        logic [7:0] prev;
        prev = led;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (led == prev && n < 64);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; swt = 8'hFF; btn_step = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (led !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_led cyc%0d: got %h want 00", i, led);
            end
        end
        rst = 1'b0; swt = 8'h3F;
        wait_clk(2);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++;
            $display("FAIL pass_latency2: got %h want 00", led);
        end
        wait_clk(1);
        vectors++;
        if (led !== 8'h3F) begin
            miscompares++;
            $display("FAIL pass_latency3: got %h want 3f", led);
        end
    endtask

    task automatic test_count;
        int n;
        swt = 8'hD8;
        wait_change(n);
        vectors++;
        if (n !== 3 || led !== 8'h00) begin
            miscompares++;
            $display("FAIL cnt_enter: got led %h after %0d clk, want 00 after 3", led, n);
        end
        for (int i = 1; i <= 3; i++) begin
            wait_change(n);
            vectors++;
            if (n !== 4 || led !== 8'(i)) begin
                miscompares++;
                $display("FAIL cnt_step%0d: got led %h after %0d clk, want %h after 4", i, led, n, 8'(i));
            end
        end
    endtask

    task automatic test_rotate;
        int n;
        swt = 8'h58;
        wait_clk(3);
        vectors++;
        if (led !== 8'h01) begin
            miscompares++;
            $display("FAIL rot_init: got %h want 01", led);
        end
        for (int i = 0; i < 8; i++) begin
            wait_change(n);
            vectors++;
            if (n !== 4 || led !== rot_tbl[i]) begin
                miscompares++;
                $display("FAIL rot_step%0d: got led %h after %0d clk, want %h after 4", i, led, n, rot_tbl[i]);
            end
        end
    endtask

    task automatic test_bounce;
        int n;
        swt = 8'h98;
        wait_clk(3);
        vectors++;
        if (led !== 8'h01) begin
            miscompares++;
            $display("FAIL bnc_init: got %h want 01", led);
        end
        for (int i = 0; i < 15; i++) begin
            wait_change(n);
            vectors++;
            if (n !== 4 || led !== bnc_tbl[i]) begin
                miscompares++;
                $display("FAIL bnc_step%0d: got led %h after %0d clk, want %h after 4", i, led, n, bnc_tbl[i]);
            end
        end
    endtask

    task automatic test_count_wrap;
        int n;
        swt = 8'hD8;
        wait_clk(3);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++;
            $display("FAIL wrap_init: got %h want 00", led);
        end
        for (int i = 1; i <= 255; i++) begin
            wait_change(n);
            vectors++;
            if (led !== 8'(i)) begin
                miscompares++;
                $display("FAIL wrap_count%0d: got %h want %h", i, led, 8'(i));
            end
        end
        wait_change(n);
        vectors++;
        if (n !== 4 || led !== 8'h00) begin
            miscompares++;
            $display("FAIL wrap_ff_to_00: got led %h after %0d clk, want 00 after 4", led, n);
        end
        wait_change(n);
        // Pin change lands so the mode change meets the next tick on the same clock.
        wait_clk(1);
        swt = 8'h58;
        wait_clk(2);
        vectors++;
        if (led !== 8'h01) begin
            miscompares++;
            $display("FAIL switch_pre: got %h want 01", led);
        end
        wait_clk(1);
        vectors++;
        if (led !== 8'h01) begin
            miscompares++;
            $display("FAIL switch_vs_tick: got %h want 01", led);
        end
        wait_change(n);
        vectors++;
        if (n !== 4 || led !== 8'h02) begin
            miscompares++;
            $display("FAIL switch_restart: got led %h after %0d clk, want 02 after 4", led, n);
        end
    endtask

    task automatic test_pause;
        logic [7:0] frozen, prev, want;
        int changes, n;
        swt = 8'h78;
        wait_clk(3);
        frozen = led;
        changes = 0;
        for (int i = 0; i < 40; i++) begin
            prev = led;
            @(negedge clk);
            if (led != prev) changes++;
        end
        vectors++;
        if (changes !== 0 || led !== frozen) begin
            miscompares++;
            $display("FAIL pause_freeze: got %h with %0d changes, want %h with 0", led, changes, frozen);
        end
        btn_step = 1'b1;
        wait_clk(2);
        btn_step = 1'b0;
        wait_clk(10);
        vectors++;
        if (led !== frozen) begin
            miscompares++;
            $display("FAIL pause_glitch: got %h want %h", led, frozen);
        end
        want = {frozen[6:0], frozen[7]};
        changes = 0;
        btn_step = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i == 20) btn_step = 1'b0;
            prev = led;
            @(negedge clk);
            if (led != prev) changes++;
        end
        vectors++;
        if (changes !== 1 || led !== want) begin
            miscompares++;
            $display("FAIL pause_step: got %h with %0d changes, want %h with 1", led, changes, want);
        end
        swt = 8'h58;
        btn_step = 1'b1;
        want = led;
        for (int i = 0; i < 3; i++) begin
            want = {want[6:0], want[7]};
            wait_change(n);
            vectors++;
            if (led !== want || (i > 0 && n !== 4)) begin
                miscompares++;
                $display("FAIL unpaused_press%0d: got led %h after %0d clk, want %h", i, led, n, want);
            end
        end
        btn_step = 1'b0;
    endtask

    task automatic test_reset_mid;
        swt = 8'h58;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_clk(3);
        wait_clk(3);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (led !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid: got %h want 00", led);
        end
        rst = 1'b0;
        wait_clk(3);
        vectors++;
        if (led !== 8'h01) begin
            miscompares++;
            $display("FAIL reset_recover: got %h want 01", led);
        end
    endtask

    task automatic test_pwm;
        int ones, bad;
        swt = 8'h07;
        wait_clk(4);
        ones = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led == 8'h07) ones++;
            else if (led != 8'h00) bad++;
        end
        vectors++;
`ifdef LED_SEQ_PWM_EN
        if (ones !== 4 || bad !== 0) begin
            miscompares++;
            $display("FAIL pwm_duty00: got %0d on / %0d bad of 16, want 4 on / 0 bad", ones, bad);
        end
`else
        if (ones !== 16) begin
            miscompares++;
            $display("FAIL pwm_off_duty00: got %0d on of 16, want 16", ones);
        end
`endif
        swt = 8'h1F;
        wait_clk(4);
        ones = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (led == 8'h1F) ones++;
        end
        vectors++;
        if (ones !== 16) begin
            miscompares++;
            $display("FAIL pwm_duty11: got %0d on of 16, want 16", ones);
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_rotate();
        test_bounce();
        test_count_wrap();
        test_pause();
        test_reset_mid();
        test_pwm();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
